// File: rtl/ped_request.sv
// Pedestrian push-button conditioner: 2-FF sync, debounce, press pulse and req/ack request FSM.
// Define PED_REQ_QUEUE_EN to remember a press made during lockout and serve it at expiry.
module ped_request #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int LOCKOUT_CYCLES  = 27_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       ack,
  output logic       req,
  output logic       press_pulse,
  output logic       lockout,
  output logic [7:0] req_count,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  // Handshake: req is a level that rises on an accepted press and stays high
  // until ack is sampled high at a clock edge; ack outside PENDING has no effect.

  logic          sync1, s;
  logic          deb, deb_d;
  logic [DW-1:0] deb_cnt;
  logic [LW-1:0] lock_cnt;
  logic [1:0]    state, state_next;
  logic          lock_done;
  logic          take_queued;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= btn_n;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else if (s != deb) begin
      if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb     <= s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // deb_d lags deb by one cycle so the pulse lands the cycle after the falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d       <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      deb_d       <= deb;
      press_pulse <= deb_d & ~deb;
    end
  end

  assign lock_done = (state == ST_LOCKOUT) && (lock_cnt == LW'(LOCKOUT_CYCLES - 1));

`ifdef PED_REQ_QUEUE_EN
  logic queued;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queued <= 1'b0;
    end else if (lock_done) begin
      queued <= 1'b0;
    end else if (state == ST_LOCKOUT && press_pulse) begin
      queued <= 1'b1;
    end
  end

  // A press arriving on the expiry edge itself still counts as made during lockout
  assign take_queued = queued | press_pulse;
`else
  assign take_queued = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (press_pulse) state_next = ST_PENDING;
      ST_PENDING: if (ack) state_next = ST_LOCKOUT;
      ST_LOCKOUT: if (lock_done) state_next = take_queued ? ST_PENDING : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    lockout   = 1'b0;
    state_dbg = state;
    case (state)
      ST_PENDING: req = 1'b1;
      ST_LOCKOUT: lockout = 1'b1;
      default: begin
        req     = 1'b0;
        lockout = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (state == ST_PENDING && ack) begin
      lock_cnt <= '0;
    end else if (state == ST_LOCKOUT) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_count <= 8'd0;
    end else if (state_next == ST_PENDING && state != ST_PENDING) begin
      req_count <= req_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed timing checks plus random button/ack traffic
// compared every cycle against a rule-level model of the request path.
module tb_ped_request;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_n;
  logic       ack;
  logic       req;
  logic       press_pulse;
  logic       lockout;
  logic [7:0] req_count;
  logic [1:0] state_dbg;

  int tests;
  int fails;

  ped_request #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .ack(ack),
    .req(req), .press_pulse(press_pulse), .lockout(lockout),
    .req_count(req_count), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: s is btn_n two edges late; deb follows s once s has
  // disagreed for D consecutive samples; pulse is the cycle after deb falls.
  logic    m_s1, m_s2, m_deb, m_pulse, m_pend, m_queued;
  int      m_run, m_lock, m_count;
  longint  m_cyc, m_fell_at;

  always @(posedge clk or negedge rst_n) begin
    logic press, s_now;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_pulse = 1'b0;
      m_pend = 1'b0; m_queued = 1'b0; m_run = 0; m_lock = 0; m_count = 0;
      m_cyc = 0; m_fell_at = -10;
    end else begin
      press = m_pulse;
      s_now = m_s2;
      m_s2  = m_s1;
      m_s1  = btn_n;
      m_cyc = m_cyc + 1;
      m_pulse = (m_cyc == m_fell_at + 1);
      if (s_now != m_deb) begin
        if (m_run == D - 1) begin
          m_deb = s_now;
          m_run = 0;
          if (!s_now) m_fell_at = m_cyc;
        end else begin
          m_run = m_run + 1;
        end
      end else begin
        m_run = 0;
      end
      if (m_pend) begin
        if (ack) begin
          m_pend = 1'b0;
          m_lock = L;
        end
      end else if (m_lock > 0) begin
        m_lock = m_lock - 1;
`ifdef PED_REQ_QUEUE_EN
        if (press) m_queued = 1'b1;
        if (m_lock == 0 && m_queued) begin
          m_pend   = 1'b1;
          m_count  = m_count + 1;
          m_queued = 1'b0;
        end
`endif
      end else if (press) begin
        m_pend  = 1'b1;
        m_count = m_count + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (req !== m_pend || lockout !== (m_lock > 0) || press_pulse !== m_pulse ||
          req_count !== m_count[7:0]) begin
        fails++;
        $display("FAIL model_cmp t=%0t got req=%b lock=%b pulse=%b cnt=%0d want req=%b lock=%b pulse=%b cnt=%0d",
                 $time, req, lockout, press_pulse, req_count,
                 m_pend, (m_lock > 0), m_pulse, m_count[7:0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Sample just after an edge; inputs changed here are seen at the next edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_window(input string name);
    for (int k = 0; k <= 7; k++) begin
      step();
      chk(name, int'(press_pulse), (k == 6) ? 1 : 0);
    end
    chk({name, "_req"}, int'(req), 1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    btn_n = 1'b1;
    ack   = 1'b0;
    #23;
    chk("rst_req", int'(req), 0);
    chk("rst_lock", int'(lockout), 0);
    chk("rst_pulse", int'(press_pulse), 0);
    chk("rst_cnt", int'(req_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(100);
    chk("idle_req", int'(req), 0);
    chk("idle_cnt", int'(req_count), 0);

    // Clean press: edge 0 is the first edge after btn_n falls
    btn_n = 1'b0;
    pulse_window("clean_pulse");
    chk("clean_cnt", int'(req_count), 1);

    // Second press while pending must not accumulate
    btn_n = 1'b1;
    step(10);
    btn_n = 1'b0;
    step(10);
    chk("pend_cnt", int'(req_count), 1);
    chk("pend_req", int'(req), 1);
    btn_n = 1'b1;
    step(10);

    // Ack, with a fresh press landing inside the lockout window
    ack   = 1'b1;
    btn_n = 1'b0;
    step();
    ack = 1'b0;
    chk("ack_req", int'(req), 0);
    chk("ack_lock", int'(lockout), 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("lock_hold", int'(lockout), 1);
    end
    step();
    chk("lock_end", int'(lockout), 0);
`ifdef PED_REQ_QUEUE_EN
    chk("lock_queued_req", int'(req), 1);
    chk("lock_queued_cnt", int'(req_count), 2);
`else
    chk("lock_drop_req", int'(req), 0);
    chk("lock_drop_cnt", int'(req_count), 1);
`endif
    btn_n = 1'b1;
    step(12);
    if (!req) begin
      btn_n = 1'b0;
      step(10);
      btn_n = 1'b1;
      step(10);
    end
    chk("pre_rst_req", int'(req), 1);

    // Reset mid-PENDING clears at once, not at the next edge
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", int'(req), 0);
    chk("mid_rst_lock", int'(lockout), 0);
    chk("mid_rst_cnt", int'(req_count), 0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // 256 full press/ack rounds wrap the counter back to 0
    for (int r = 0; r < 256; r++) begin
      btn_n = 1'b0;
      step(8);
      ack = 1'b1;
      step();
      ack   = 1'b0;
      btn_n = 1'b1;
      step(12);
      if (r == 0) chk("wrap_first", int'(req_count), 1);
    end
    chk("wrap_cnt", int'(req_count), 0);

    // Bounce: 3 low, 2 high, then held low; only the final low yields a pulse
    btn_n = 1'b0;
    step(3);
    btn_n = 1'b1;
    step(2);
    btn_n = 1'b0;
    pulse_window("bounce_pulse");
    chk("bounce_cnt", int'(req_count), 1);
    ack = 1'b1;
    step();
    ack   = 1'b0;
    btn_n = 1'b1;
    step(12);

    // Random traffic: mixed short bounces and real presses, sporadic acks
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      btn_n = ~btn_n;
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(5, 16);
      for (int c = 0; c < len; c++) begin
        ack = ($urandom_range(0, 5) == 0);
        step();
      end
    end
    ack   = 1'b0;
    btn_n = 1'b1;
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
